// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - FIPS 180-4 padder and block sequencer for sha256_core (option macro: SHA256_PADDER_DOUBLE_HASH_EN)
module sha256_msg_padder #(
    parameter int LEN_W      = 64,
    parameter int READY_SKIP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic [2:0]   s_bytes,
    output logic         core_init,
    output logic         core_next,
    output logic         core_mode,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic [255:0] core_digest,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE, FILL, PAD, ISSUE, WAIT, DONE
`ifdef SHA256_PADDER_DOUBLE_HASH_EN
        , SECOND
`endif
    } state_t;

    state_t state, state_next;

    logic [31:0]      words [16];
    logic [4:0]       word_ctr;
    logic [LEN_W-1:0] len;
    logic [2:0]       last_bytes;
    logic             final_blk;
    logic             pend_len;
    logic             pend_pad;
    logic             started;
    logic [7:0]       skip_ctr;
`ifdef SHA256_PADDER_DOUBLE_HASH_EN
    logic             second_done;
`endif

    logic             accept;
    logic             wait_go;
    logic [2:0]       bytes_eff;
    logic [LEN_W-1:0] add_bits;
    logic [4:0]       last_idx;
    logic [4:0]       pad_idx;
    logic [31:0]      keep_mask;
    logic [31:0]      pad_byte;
    logic [63:0]      len64;

    assign accept    = (state == FILL) && s_valid;
    assign wait_go   = (state == WAIT) && (skip_ctr == 8'd0) && core_ready;
    assign bytes_eff = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
    assign add_bits  = s_last ? LEN_W'({bytes_eff, 3'b000}) : LEN_W'(6'd32);
    // The last word sits one slot below the counter; a full last word pushes 0x80 into the next slot.
    assign last_idx  = word_ctr - 5'd1;
    assign pad_idx   = last_idx + {4'b0000, last_bytes == 3'd4};
    assign keep_mask = ~(32'hFFFF_FFFF >> {last_bytes, 3'b000});
    assign pad_byte  = (last_bytes == 3'd4) ? 32'h0 : (32'h8000_0000 >> {last_bytes, 3'b000});
    assign len64     = 64'(len);
    assign core_mode = 1'b1;

    for (genvar g = 0; g < 16; g++) begin : g_block
        assign core_block[511-32*g -: 32] = words[g];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (core_ready) state_next = FILL;
            FILL:  if (accept) begin
                       if (s_last)                  state_next = PAD;
                       else if (word_ctr == 5'd15)  state_next = ISSUE;
                   end
            PAD:   state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (wait_go) begin
                       if (final_blk) begin
`ifdef SHA256_PADDER_DOUBLE_HASH_EN
                           state_next = second_done ? DONE : SECOND;
`else
                           state_next = DONE;
`endif
                       end else if (pend_len) begin
                           state_next = ISSUE;
                       end else begin
                           state_next = FILL;
                       end
                   end
            DONE:  state_next = IDLE;
`ifdef SHA256_PADDER_DOUBLE_HASH_EN
            SECOND: state_next = ISSUE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        s_ready      = (state == FILL);
        core_init    = (state == ISSUE) && !started;
        core_next    = (state == ISSUE) && started;
        digest_valid = (state == DONE);
    end

    // Block assembly, padding, length accounting and digest capture
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) words[i] <= '0;
            word_ctr   <= '0;
            len        <= '0;
            last_bytes <= '0;
            final_blk  <= 1'b0;
            pend_len   <= 1'b0;
            pend_pad   <= 1'b0;
            started    <= 1'b0;
            skip_ctr   <= '0;
            digest     <= '0;
            busy       <= 1'b0;
`ifdef SHA256_PADDER_DOUBLE_HASH_EN
            second_done <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: if (accept) begin
                    words[word_ctr[3:0]] <= s_data;
                    word_ctr   <= word_ctr + 5'd1;
                    len        <= len + add_bits;
                    last_bytes <= bytes_eff;
                    busy       <= 1'b1;
                end
                PAD: begin
                    for (int i = 0; i < 16; i++) begin
                        if (5'(i) == last_idx)
                            words[i] <= (words[i] & keep_mask) | pad_byte;
                        else if (5'(i) > last_idx)
                            words[i] <= (5'(i) == pad_idx) ? 32'h8000_0000 : 32'h0;
                    end
                    if (pad_idx <= 5'd13) begin
                        words[14] <= len64[63:32];
                        words[15] <= len64[31:0];
                        final_blk <= 1'b1;
                    end else begin
                        pend_len <= 1'b1;
                        pend_pad <= (pad_idx == 5'd16);
                    end
                end
                ISSUE: begin
                    started  <= 1'b1;
                    skip_ctr <= 8'(READY_SKIP);
                end
                WAIT: begin
                    if (skip_ctr != 8'd0) begin
                        skip_ctr <= skip_ctr - 8'd1;
                    end else if (core_ready) begin
                        if (final_blk) begin
`ifdef SHA256_PADDER_DOUBLE_HASH_EN
                            if (second_done) digest <= core_digest;
`else
                            digest <= core_digest;
`endif
                        end else if (pend_len) begin
                            // 0x80 only lands here when a full last word filled slot 15
                            words[0] <= pend_pad ? 32'h8000_0000 : 32'h0;
                            for (int i = 1; i < 14; i++) words[i] <= '0;
                            words[14] <= len64[63:32];
                            words[15] <= len64[31:0];
                            final_blk <= 1'b1;
                            pend_len  <= 1'b0;
                            pend_pad  <= 1'b0;
                        end else begin
                            word_ctr <= '0;
                        end
                    end
                end
`ifdef SHA256_PADDER_DOUBLE_HASH_EN
                SECOND: begin
                    for (int i = 0; i < 8; i++) words[i] <= core_digest[255-32*i -: 32];
                    words[8] <= 32'h8000_0000;
                    for (int i = 9; i < 15; i++) words[i] <= '0;
                    words[15]   <= 32'd256;
                    started     <= 1'b0;
                    second_done <= 1'b1;
                end
`endif
                DONE: begin
                    len       <= '0;
                    word_ctr  <= '0;
                    started   <= 1'b0;
                    final_blk <= 1'b0;
                    busy      <= 1'b0;
`ifdef SHA256_PADDER_DOUBLE_HASH_EN
                    second_done <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - randomized self-checking bench for sha256_msg_padder with a behavioural SHA-256 core
module tb_sha256_msg_padder;

    typedef logic [7:0]   byteq_t [$];
    typedef logic [511:0] blkq_t  [$];

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         s_last;
    logic [2:0]   s_bytes;
    logic         core_init;
    logic         core_next;
    logic         core_mode;
    logic [511:0] core_block;
    logic         core_ready;
    logic [255:0] core_digest;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_init, n_next, hold_err, rst_epoch;
    blkq_t        seen_blocks;
    logic [255:0] h_state;

    sha256_msg_padder dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes),
        .core_init(core_init), .core_next(core_next), .core_mode(core_mode), .core_block(core_block),
        .core_ready(core_ready), .core_digest(core_digest),
        .digest(digest), .digest_valid(digest_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96]  + e, hin[95:64]   + f, hin[63:32]   + g, hin[31:0]    + h};
    endfunction

    // Reference padding: byte-level FIPS 180-4 rule, then cut into 64-byte blocks
    function automatic void pad_msg(input byteq_t m, output blkq_t blks);
        byteq_t       p;
        logic [63:0]  bl;
        logic [511:0] x;
        p  = m;
        bl = 64'(m.size()) << 3;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        blks.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int j = 0; j < 64; j++) x[511-8*j -: 8] = p[64*b+j];
            blks.push_back(x);
        end
    endfunction

    function automatic void str2q(input string s, output byteq_t q);
        q.delete();
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    // Behavioural sha256_core: compresses on each pulse, drops ready for a random time
    initial begin : core_model
        logic [511:0] held;
        int           dly;
        int           ep;
        core_ready  = 1'b1;
        core_digest = '0;
        h_state     = IV;
        forever begin
            @(negedge clk);
            if (!reset && (core_init || core_next)) begin
                held = core_block;
                seen_blocks.push_back(core_block);
                if (core_init) begin n_init++; h_state = sha_compress(IV, core_block); end
                else           begin n_next++; h_state = sha_compress(h_state, core_block); end
                core_ready = 1'b0;
                ep  = rst_epoch;
                dly = $urandom_range(1, 4);
                repeat (dly) @(negedge clk);
                core_digest = h_state;
                core_ready  = 1'b1;
                if (ep == rst_epoch && core_block !== held) hold_err++;
            end
        end
    end

    task automatic send_msg(input byteq_t m, input bit gaps, input bit zero_term, output bit tmo);
        int          nw, cyc;
        logic [31:0] w;
        bit          lst;
        tmo = 1'b0;
        nw  = m.size() / 4;
        if ((m.size() % 4 != 0) || m.size() == 0 || zero_term) nw++;
        for (int i = 0; i < nw; i++) begin
            w   = $urandom();
            lst = (i == nw - 1);
            for (int j = 0; j < 4; j++) if (4*i + j < m.size()) w[31-8*j -: 8] = m[4*i+j];
            s_data  = w;
            s_last  = lst;
            s_bytes = lst ? 3'(m.size() - 4*i) : 3'($urandom_range(0, 7));
            s_valid = 1'b1;
            cyc = 0;
            while (!s_ready && cyc < 200) begin @(negedge clk); cyc++; end
            if (!s_ready) begin tmo = 1'b1; s_valid = 1'b0; return; end
            @(negedge clk);
            if (gaps) begin s_valid = 1'b0; @(negedge clk); end
        end
        s_valid = 1'b0;
    endtask

    task automatic run_msg(input byteq_t m, input bit gaps, input bit zero_term, input bit junk,
                           output logic [255:0] got);
        blkq_t        exp_b;
        logic [255:0] hh;
        bit           tmo, seen;
        int           rdy_hi, nmsg, exp_init;
        pad_msg(m, exp_b);
        nmsg = exp_b.size();
        hh   = IV;
        foreach (exp_b[i]) hh = sha_compress(hh, exp_b[i]);
        exp_init = 1;
`ifdef SHA256_PADDER_DOUBLE_HASH_EN
        exp_b.push_back({hh, 32'h8000_0000, 160'b0, 64'd256});
        hh = sha_compress(IV, exp_b[exp_b.size()-1]);
        exp_init = 2;
`endif
        n_init = 0; n_next = 0; seen_blocks.delete();
        got = '0;
        send_msg(m, gaps, zero_term, tmo);
        check_eq("accept_tmo", tmo, 0);
        check_eq("busy_mid", busy, 1);
        if (junk) begin
            s_valid = 1'b1; s_data = $urandom(); s_last = 1'($urandom()); s_bytes = 3'($urandom_range(0, 7));
        end
        seen = 1'b0; rdy_hi = 0;
        for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
            @(negedge clk);
            if (digest_valid) begin seen = 1'b1; got = digest; end
            else if (s_ready) rdy_hi++;
        end
        s_valid = 1'b0;
        check_eq("digest_valid_seen", seen, 1);
        check_eq("digest", got, hh);
        check_eq("n_init", n_init, exp_init);
        check_eq("n_next", n_next, nmsg - 1);
        check_eq("n_blocks", seen_blocks.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < seen_blocks.size(); i++)
            check_eq($sformatf("block%0d", i), seen_blocks[i], exp_b[i]);
        check_eq("s_ready_outside_fill", rdy_hi, 0);
        check_eq("block_hold", hold_err, 0);
        @(negedge clk);
        check_eq("busy_after", busy, 0);
        check_eq("s_ready_lat1", s_ready, 0);
        @(negedge clk);
        check_eq("s_ready_lat2", s_ready, 1);
    endtask

    initial begin
        byteq_t       m;
        logic [255:0] got;
        bit           tmo;
        int           cyc, n;
        n_init = 0; n_next = 0; hold_err = 0; rst_epoch = 0;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_bytes = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_core_init", core_init, 0);
        check_eq("rst_core_next", core_next, 0);
        check_eq("rst_core_block", core_block, 0);
        check_eq("rst_digest", digest, 0);
        check_eq("rst_digest_valid", digest_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("core_mode", core_mode, 1);
        reset = 1'b0;
        @(negedge clk);

        str2q("abc", m);
        run_msg(m, 1'b0, 1'b0, 1'b0, got);
`ifdef SHA256_PADDER_DOUBLE_HASH_EN
        check_eq("tc6_abc_double", got, 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358);
`else
        check_eq("tc1_abc", got, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
`endif

        m.delete();
        run_msg(m, 1'b0, 1'b0, 1'b0, got);
        check_eq("tc2_empty_block", seen_blocks[0], {32'h8000_0000, 480'b0});
`ifndef SHA256_PADDER_DOUBLE_HASH_EN
        check_eq("tc2_empty", got, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
`endif

        str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", m);
        run_msg(m, 1'b0, 1'b0, 1'b1, got);
`ifndef SHA256_PADDER_DOUBLE_HASH_EN
        check_eq("tc3_448", got, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
`endif

        str2q("tanphandev", m);
        run_msg(m, 1'b1, 1'b0, 1'b1, got);
`ifndef SHA256_PADDER_DOUBLE_HASH_EN
        check_eq("tc4_tanphandev", got, 256'h85e9a47fc5dc216f9b3ff562488d35c93210cfd8d265688dfeb0612c56f76886);
`endif

        // Reset in the middle of a two-block message
        m.delete();
        for (int i = 0; i < 60; i++) m.push_back(8'($urandom()));
        n_init = 0; seen_blocks.delete();
        send_msg(m, 1'b0, 1'b0, tmo);
        cyc = 0;
        while (n_init == 0 && cyc < 200) begin @(negedge clk); cyc++; end
        check_eq("tc5_reached_wait", n_init, 1);
        @(negedge clk);
        rst_epoch++;
        reset = 1'b1;
        @(negedge clk);
        check_eq("tc5_s_ready", s_ready, 0);
        check_eq("tc5_core_init", core_init, 0);
        check_eq("tc5_core_next", core_next, 0);
        check_eq("tc5_core_block", core_block, 0);
        check_eq("tc5_digest", digest, 0);
        check_eq("tc5_digest_valid", digest_valid, 0);
        check_eq("tc5_busy", busy, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        str2q("abc", m);
        run_msg(m, 1'b0, 1'b0, 1'b0, got);
`ifndef SHA256_PADDER_DOUBLE_HASH_EN
        check_eq("tc5_rerun_abc", got, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
`endif

        // Random lengths covering every slot/byte alignment and multi-block messages
        for (int r = 0; r < 30; r++) begin
            m.delete();
            n = $urandom_range(0, 140);
            for (int i = 0; i < n; i++) m.push_back(8'($urandom()));
            run_msg(m, 1'($urandom()), 1'($urandom()), 1'($urandom()), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
